// File: rtl/sync_prog_rom.sv
// sync_prog_rom: clocked program ROM with valid/ready read pipeline and lockable programming port
module sync_prog_rom #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 65536,
  parameter int                LATENCY   = 1,
  parameter logic [DATA_W-1:0] FILL      = '0,
  parameter string             INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              lock_req,
  output logic              locked,
  output logic              prog_err
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] BOOT [5] = '{8'h01, 8'h00, 8'h16, 8'h48, 8'hFC};
  typedef logic [DATA_W-1:0] mem_t [DEPTH];
  function automatic mem_t init_image();
    mem_t img;
    for (int i = 0; i < DEPTH; i++) img[i] = '0;
    for (int i = 0; i < 5 && i < DEPTH; i++) img[i] = DATA_W'(BOOT[i]);
    return img;
  endfunction
  mem_t mem_q = init_image();
  logic [LATENCY-1:0] v_q, v_d, e_q, e_d;
  logic [DATA_W-1:0]  d_q [LATENCY];
  logic [DATA_W-1:0]  d_d [LATENCY];
  logic               locked_q, prog_err_q, stall, rd_in, wr_in, wr_ok;
  logic [DATA_W-1:0]  rd_word;
  assign stall     = v_q[LATENCY-1] && !rsp_ready;
  assign req_ready = !stall;
  assign rd_in     = {1'b0, req_addr} < (ADDR_W+1)'(DEPTH);
  assign wr_in     = {1'b0, prog_addr} < (ADDR_W+1)'(DEPTH);
  assign wr_ok     = prog_we && !locked_q && wr_in;
  assign rd_word   = rd_in ? mem_q[req_addr[IW-1:0]] : FILL;
  assign rsp_valid = v_q[LATENCY-1];
  assign rsp_data  = d_q[LATENCY-1];
  assign rsp_err   = e_q[LATENCY-1];
  assign locked    = locked_q;
  assign prog_err  = prog_err_q;
  // shift the read pipe unless the consumer is stalling; payload only moves with a valid word so rsp_data holds
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    e_d = e_q;
    if (!stall) begin
      v_d[0] = req_valid;
      d_d[0] = req_valid ? rd_word : d_q[0];
      e_d[0] = req_valid ? !rd_in : e_q[0];
      for (int i = 1; i < LATENCY; i++) begin
        v_d[i] = v_q[i-1];
        d_d[i] = v_q[i-1] ? d_q[i-1] : d_q[i];
        e_d[i] = v_q[i-1] ? e_q[i-1] : e_q[i];
      end
    end
  end
  // pipeline, sticky lock and rejected-write pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q        <= '0;
      d_q        <= '{default: '0};
      e_q        <= '0;
      locked_q   <= 1'b0;
      prog_err_q <= 1'b0;
    end else begin
      v_q        <= v_d;
      d_q        <= d_d;
      e_q        <= e_d;
      locked_q   <= locked_q || lock_req;
      prog_err_q <= prog_we && (locked_q || !wr_in);
    end
  end
  // storage write port; reads sample the old word on a same-edge collision
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[prog_addr[IW-1:0]] <= prog_data;
  end
endmodule

// File: tb/tb_sync_prog_rom.sv
// tb_sync_prog_rom: checks two ROM instances (latency 1 and 3) against a scoreboard model
module tb_sync_prog_rom;
  localparam int LAT [2] = '{1, 3};
  logic        clk = 1'b0, rst;
  logic        req_valid, rsp_ready, prog_we, lock_req;
  logic [15:0] req_addr, prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  req_ready, rsp_valid, rsp_err, locked, prog_err;
  logic [7:0]  rsp_data [2];
  int n_chk = 0, n_fail = 0;
  logic [7:0] mem_m [256];
  logic       lock_m, perr_m;
  logic [8:0] sbq [2][$];
  logic [1:0] stall_prev;
  logic [8:0] hold_w [2];
  logic [8:0] last_vis [2];
  int delivered [2];
  int stalls [2];
  typedef struct { logic [15:0] addr; logic [7:0] data; logic err; } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  sync_prog_rom #(.DATA_W(8), .ADDR_W(16), .DEPTH(256), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[0]), .req_addr(req_addr),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .lock_req(lock_req),
    .locked(locked[0]), .prog_err(prog_err[0]));

  sync_prog_rom #(.DATA_W(8), .ADDR_W(16), .DEPTH(256), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[1]), .req_addr(req_addr),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .lock_req(lock_req),
    .locked(locked[1]), .prog_err(prog_err[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] exp_rd(input logic [15:0] a);
    return (a >= 16'd256) ? {1'b1, 8'h00} : {1'b0, mem_m[a[7:0]]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      sbq[i].delete();
      last_vis[i] = '0;
    end
    stall_prev = '0;
    lock_m = 1'b0;
    perr_m = 1'b0;
  endtask

  task automatic cycle(input logic rv, input logic [15:0] ra, input logic rr, input logic we,
                       input logic [15:0] wa, input logic [7:0] wd, input logic lk, output logic [1:0] acc);
    logic [8:0] e;
    @(negedge clk);
    req_valid = rv; req_addr = ra; rsp_ready = rr;
    prog_we = we; prog_addr = wa; prog_data = wd; lock_req = lk;
    #1;
    acc = '0;
    for (int i = 0; i < 2; i++) begin
      chk("locked", locked[i], lock_m);
      chk("prog_err", prog_err[i], perr_m);
      if (stall_prev[i]) begin
        chk("stall_valid", rsp_valid[i], 1);
        chk("stall_hold", {rsp_err[i], rsp_data[i]}, hold_w[i]);
      end else if (!rsp_valid[i]) begin
        chk("idle_hold", {rsp_err[i], rsp_data[i]}, last_vis[i]);
      end
      chk("req_ready", req_ready[i], !(rsp_valid[i] && !rr));
      if (rsp_valid[i]) last_vis[i] = {rsp_err[i], rsp_data[i]};
      if (rsp_valid[i] && !rr) stalls[i]++;
      if (rsp_valid[i] && rr) begin
        if (sbq[i].size() == 0) chk("spurious_rsp", rsp_valid[i], 0);
        else begin
          e = sbq[i].pop_front();
          chk("rsp_word", {rsp_err[i], rsp_data[i]}, e);
          delivered[i]++;
        end
      end
      stall_prev[i] = rsp_valid[i] && !rr;
      hold_w[i] = {rsp_err[i], rsp_data[i]};
      if (rv && req_ready[i]) begin
        acc[i] = 1'b1;
        sbq[i].push_back(exp_rd(ra));
      end
    end
    perr_m = we && (lock_m || wa >= 16'd256);
    if (we && !lock_m && wa < 16'd256) mem_m[wa[7:0]] = wd;
    if (lk) lock_m = 1'b1;
  endtask

  task automatic idle(input int n);
    logic [1:0] acc;
    for (int k = 0; k < n; k++) cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 8'h00, 1'b0, acc);
  endtask

  task automatic drain();
    logic [1:0] acc;
    for (int k = 0; k < 30 && (sbq[0].size() != 0 || sbq[1].size() != 0); k++)
      cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 8'h00, 1'b0, acc);
    chk("drain_q0", sbq[0].size(), 0);
    chk("drain_q1", sbq[1].size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] acc;
    int a, t;
    tbl[0] = '{16'h0000, 8'h01, 1'b0};
    tbl[1] = '{16'h0001, 8'h00, 1'b0};
    tbl[2] = '{16'h0002, 8'h16, 1'b0};
    tbl[3] = '{16'h0003, 8'h48, 1'b0};
    tbl[4] = '{16'h0004, 8'hFC, 1'b0};
    tbl[5] = '{16'h0100, 8'h00, 1'b1};
    tbl[6] = '{16'h00FF, 8'h00, 1'b0};
    tbl[7] = '{16'hFFFF, 8'h00, 1'b1};
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    mem_m[0] = 8'h01; mem_m[2] = 8'h16; mem_m[3] = 8'h48; mem_m[4] = 8'hFC;
    delivered = '{0, 0};
    stalls = '{0, 0};
    model_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0; lock_req = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("rst_rsp_valid", rsp_valid[i], 0);
      chk("rst_rsp_data", rsp_data[i], 0);
      chk("rst_rsp_err", rsp_err[i], 0);
      chk("rst_locked", locked[i], 0);
      chk("rst_prog_err", prog_err[i], 0);
      chk("rst_req_ready", req_ready[i], 1);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    // back-to-back reads: exact latency and table data per instance
    for (int k = 0; k < 11; k++) begin
      cycle(k < 8, (k < 8) ? tbl[k].addr : 16'h0, 1'b1, 1'b0, 16'h0, 8'h00, 1'b0, acc);
      for (int i = 0; i < 2; i++) begin
        chk("tbl_valid", rsp_valid[i], (k >= LAT[i]) && (k - LAT[i] < 8));
        if ((k >= LAT[i]) && (k - LAT[i] < 8)) begin
          chk("tbl_data", rsp_data[i], tbl[k - LAT[i]].data);
          chk("tbl_err", rsp_err[i], tbl[k - LAT[i]].err);
        end
      end
    end
    drain();
    // consumer stalls for 4 cycles mid-stream of 8 requests
    delivered = '{0, 0};
    stalls = '{0, 0};
    a = 0; t = 0;
    while (a < 8 && t < 40) begin
      cycle(1'b1, 16'(a), !(t >= 4 && t < 8), 1'b0, 16'h0, 8'h00, 1'b0, acc);
      if (acc[1]) a++;
      t++;
    end
    chk("stall_issued", a, 8);
    drain();
    chk("stall_cycles_l3", stalls[1], 4);
    chk("stall_delivered_l3", delivered[1], 8);
    // same-edge write and read of 0x20 returns the old word, then the new one
    cycle(1'b1, 16'h0020, 1'b1, 1'b1, 16'h0020, 8'h77, 1'b0, acc);
    cycle(1'b1, 16'h0020, 1'b1, 1'b0, 16'h0, 8'h00, 1'b0, acc);
    drain();
    // out-of-range read and write; word 0 must not be aliased
    cycle(1'b1, 16'h0100, 1'b1, 1'b1, 16'h0100, 8'h5A, 1'b0, acc);
    cycle(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0, 8'h00, 1'b0, acc);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0, 8'h00, 1'b0, acc);
    drain();
    // randomized traffic against the scoreboard
    for (int k = 0; k < 300; k++) begin
      int r;
      logic [15:0] ra, wa;
      r = $urandom_range(0, 9);
      ra = (r < 7) ? 16'($urandom_range(0, 127)) : (r == 7) ? 16'($urandom_range(128, 255)) :
           (r == 8) ? 16'($urandom_range(256, 65535)) : 16'h0100;
      wa = ($urandom_range(0, 9) == 0) ? 16'h1000 : 16'(16'h40 + $urandom_range(0, 63));
      cycle($urandom_range(0, 3) != 0, ra, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            wa, 8'($urandom_range(0, 255)), 1'b0, acc);
    end
    drain();
    // write together with lock request, then a rejected write
    cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h0010, 8'hAA, 1'b1, acc);
    cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h0010, 8'h55, 1'b0, acc);
    cycle(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0, 8'h00, 1'b0, acc);
    idle(2);
    drain();
    // asynchronous reset with requests in flight
    cycle(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0, 8'h00, 1'b0, acc);
    cycle(1'b1, 16'h0011, 1'b1, 1'b0, 16'h0, 8'h00, 1'b0, acc);
    @(negedge clk);
    #3;
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("arst_rsp_valid", rsp_valid[i], 0);
      chk("arst_rsp_data", rsp_data[i], 0);
      chk("arst_rsp_err", rsp_err[i], 0);
      chk("arst_locked", locked[i], 0);
      chk("arst_prog_err", prog_err[i], 0);
    end
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    idle(6);
    cycle(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0, 8'h00, 1'b0, acc);
    drain();
    chk("mem_kept_0x10", mem_m[8'h10], 8'hAA);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
